keypad_emulator: RTL

- Behavioural-synthesizable responder for the 4x4 keypad scan interface.
- Acts as the keypad itself: it watches the column selector driven by the keypad scanner and returns the row code and valid strobe for one scripted key press at a time.
- Used for board bring-up and scripted calculator input replay in place of the physical matrix.
- A simple ready/valid handshake accepts key codes 0x0..0xF.

---
 rtl/keypad_emulator.sv | 107 ++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// Scripted 4x4 keypad responder: accepts one key code at a time and answers the
// scanner's column selector with that key's row code for HOLD_SCANS matching scans.
module keypad_emulator #(
  parameter int unsigned HOLD_SCANS = 3,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       press_valid,
  input  logic [3:0] key_code,
  output logic       press_ready,
  input  logic [1:0] col_selector,
  output logic [1:0] row_result,
  output logic       valid_out,
  output logic       done
);

  localparam logic [7:0] HoldLast = 8'(HOLD_SCANS - 1);
  localparam logic [7:0] GapLast  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StRelease, StDone} state_e;

  state_e     state_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] gap_cnt_q;
  logic [1:0] col_q;
  logic [1:0] row_q;
  logic       done_q;

  logic [1:0] key_col;
  logic [1:0] key_row;
  logic [1:0] active_col;

  // Matrix position of each key; column index counts from the letter column.
  always_comb begin
    key_col = 2'd0;
    key_row = 2'd0;
    unique case (key_code)
      4'h0: {key_col, key_row} = {2'd2, 2'b00};
      4'h1: {key_col, key_row} = {2'd3, 2'b11};
      4'h2: {key_col, key_row} = {2'd2, 2'b11};
      4'h3: {key_col, key_row} = {2'd1, 2'b11};
      4'h4: {key_col, key_row} = {2'd3, 2'b10};
      4'h5: {key_col, key_row} = {2'd2, 2'b10};
      4'h6: {key_col, key_row} = {2'd1, 2'b10};
      4'h7: {key_col, key_row} = {2'd3, 2'b01};
      4'h8: {key_col, key_row} = {2'd2, 2'b01};
      4'h9: {key_col, key_row} = {2'd1, 2'b01};
      4'hA: {key_col, key_row} = {2'd0, 2'b11};
      4'hB: {key_col, key_row} = {2'd0, 2'b10};
      4'hC: {key_col, key_row} = {2'd0, 2'b01};
      4'hD: {key_col, key_row} = {2'd0, 2'b00};
      4'hE: {key_col, key_row} = {2'd1, 2'b00};
      4'hF: {key_col, key_row} = {2'd3, 2'b00};
      default: {key_col, key_row} = {2'd0, 2'b00};
    endcase
  end

  // Combinational from col_selector so it settles before the scanner samples.
  assign active_col  = ~col_selector;
  assign valid_out   = (state_q == StPress) && (active_col == col_q);
  assign row_result  = valid_out ? row_q : 2'b00;
  assign press_ready = (state_q == StIdle);
  assign done        = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      hold_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      col_q      <= 2'd2;  // position of key 0
      row_q      <= 2'b00;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (press_valid) begin
            col_q      <= key_col;
            row_q      <= key_row;
            hold_cnt_q <= 8'd0;
            state_q    <= StPress;
          end
        end
        StPress: begin
          if (valid_out) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
            if (hold_cnt_q == HoldLast) begin
              gap_cnt_q <= 8'd0;
              state_q   <= StRelease;
            end
          end
        end
        StRelease: begin
          gap_cnt_q <= gap_cnt_q + 8'd1;
          if (gap_cnt_q == GapLast) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
